// File: rtl/pet2001_ps2_key_pkg.sv
// Shared types and constants for the PS/2 to PET 2001 keyboard matrix bridge.
package pet2001_ps2_key_pkg;

    localparam int unsigned KEY_ROWS = 10;
    localparam int unsigned KEY_COLS = 8;
    localparam int unsigned ROW_W    = 4;
    localparam int unsigned COL_W    = 3;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_REL  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic             hit;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } key_loc_t;

    function automatic key_loc_t key_at(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
        key_at.hit = 1'b1;
        key_at.row = row;
        key_at.col = col;
    endfunction

endpackage

// File: rtl/pet2001_ps2_keymap.sv
// Combinational PS/2 set-2 scan code to PET keyboard matrix position table.
module pet2001_ps2_keymap
    import pet2001_ps2_key_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output key_loc_t   loc_c
);

    always_comb begin
        loc_c = '0;
        case ({ext, code})
            9'h01C: loc_c = key_at(4'd4, 3'd0);  // A
            9'h023: loc_c = key_at(4'd4, 3'd1);  // D
            9'h034: loc_c = key_at(4'd4, 3'd2);  // G
            9'h03B: loc_c = key_at(4'd4, 3'd3);  // J
            9'h04B: loc_c = key_at(4'd4, 3'd4);  // L
            9'h025: loc_c = key_at(4'd4, 3'd6);  // 4
            9'h036: loc_c = key_at(4'd4, 3'd7);  // 6
            9'h015: loc_c = key_at(4'd2, 3'd0);  // Q
            9'h024: loc_c = key_at(4'd2, 3'd1);  // E
            9'h02C: loc_c = key_at(4'd2, 3'd2);  // T
            9'h03C: loc_c = key_at(4'd2, 3'd3);  // U
            9'h044: loc_c = key_at(4'd2, 3'd4);  // O
            9'h03D: loc_c = key_at(4'd2, 3'd6);  // 7
            9'h046: loc_c = key_at(4'd2, 3'd7);  // 9
            9'h01D: loc_c = key_at(4'd3, 3'd0);  // W
            9'h02D: loc_c = key_at(4'd3, 3'd1);  // R
            9'h035: loc_c = key_at(4'd3, 3'd2);  // Y
            9'h043: loc_c = key_at(4'd3, 3'd3);  // I
            9'h04D: loc_c = key_at(4'd3, 3'd4);  // P
            9'h03E: loc_c = key_at(4'd3, 3'd6);  // 8
            9'h01B: loc_c = key_at(4'd5, 3'd0);  // S
            9'h02B: loc_c = key_at(4'd5, 3'd1);  // F
            9'h033: loc_c = key_at(4'd5, 3'd2);  // H
            9'h042: loc_c = key_at(4'd5, 3'd3);  // K
            9'h02E: loc_c = key_at(4'd5, 3'd6);  // 5
            9'h01A: loc_c = key_at(4'd6, 3'd0);  // Z
            9'h021: loc_c = key_at(4'd6, 3'd1);  // C
            9'h032: loc_c = key_at(4'd6, 3'd2);  // B
            9'h03A: loc_c = key_at(4'd6, 3'd3);  // M
            9'h05A: loc_c = key_at(4'd6, 3'd5);  // RETURN
            9'h016: loc_c = key_at(4'd6, 3'd6);  // 1
            9'h026: loc_c = key_at(4'd6, 3'd7);  // 3
            9'h022: loc_c = key_at(4'd7, 3'd0);  // X
            9'h02A: loc_c = key_at(4'd7, 3'd1);  // V
            9'h031: loc_c = key_at(4'd7, 3'd2);  // N
            9'h01E: loc_c = key_at(4'd7, 3'd6);  // 2
            9'h012: loc_c = key_at(4'd8, 3'd0);  // left shift
            9'h059: loc_c = key_at(4'd8, 3'd5);  // right shift
            9'h045: loc_c = key_at(4'd8, 3'd6);  // 0
            9'h029: loc_c = key_at(4'd9, 3'd2);  // SPACE
            9'h066: loc_c = key_at(4'd1, 3'd7);  // backspace -> DEL
            9'h175: loc_c = key_at(4'd1, 3'd0);  // up arrow
            9'h172: loc_c = key_at(4'd1, 3'd6);  // down arrow
            9'h16C: loc_c = key_at(4'd0, 3'd6);  // HOME
            9'h174: loc_c = key_at(4'd0, 3'd7);  // right arrow
            default: loc_c = '0;
        endcase
    end

endmodule

// File: rtl/pet2001_ps2_key.sv
// PS/2 keyboard receiver feeding a 10x8 PET keyboard matrix scanned via keyrow/keyin.
module pet2001_ps2_key
    import pet2001_ps2_key_pkg::*;
#(
    parameter int unsigned TIMEOUT = 20000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    input  logic [ROW_W-1:0] keyrow,
    output logic [7:0]       keyin
);

    localparam int unsigned    TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef logic [KEY_ROWS-1:0][KEY_COLS-1:0] matrix_t;

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_prev;
    logic       fall;
    logic       bit_in;

    rx_state_t       state_q, state_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic            parity_q, parity_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            byte_valid_q, byte_valid_d;
    logic [7:0]      rx_byte_q, rx_byte_d;

    logic    rel_q, rel_d;
    logic    ext_q, ext_d;
    matrix_t matrix_q, matrix_d;
    key_loc_t loc;

    // Idle-high lines reset to 1 so leaving reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[1];
    assign bit_in = data_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RX_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            parity_q     <= 1'b0;
            to_cnt_q     <= '0;
            byte_valid_q <= 1'b0;
            rx_byte_q    <= '0;
            rel_q        <= 1'b0;
            ext_q        <= 1'b0;
            matrix_q     <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            parity_q     <= parity_d;
            to_cnt_q     <= to_cnt_d;
            byte_valid_q <= byte_valid_d;
            rx_byte_q    <= rx_byte_d;
            rel_q        <= rel_d;
            ext_q        <= ext_d;
            matrix_q     <= matrix_d;
        end
    end

    // Frame receiver: start, 8 data LSB first, odd parity, stop.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        parity_d     = parity_q;
        to_cnt_d     = to_cnt_q;
        byte_valid_d = 1'b0;
        rx_byte_d    = rx_byte_q;

        if (state_q != RX_IDLE) begin
            if (fall) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TO_LAST) begin
                state_d   = RX_IDLE;
                shift_d   = '0;
                bit_cnt_d = '0;
                to_cnt_d  = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end

        if (fall) begin
            case (state_q)
                RX_IDLE: begin
                    if (!bit_in) begin
                        state_d   = RX_DATA;
                        shift_d   = '0;
                        bit_cnt_d = '0;
                        to_cnt_d  = '0;
                    end
                end
                RX_DATA: begin
                    shift_d = {bit_in, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = RX_PARITY;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                RX_PARITY: begin
                    parity_d = bit_in;
                    state_d  = RX_STOP;
                end
                RX_STOP: begin
                    if (bit_in && ((^shift_q) ^ parity_q)) begin
                        byte_valid_d = 1'b1;
                        rx_byte_d    = shift_q;
                    end
                    state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    pet2001_ps2_keymap u_keymap (
        .ext   (ext_q),
        .code  (rx_byte_q),
        .loc_c (loc)
    );

    // Prefix flags and key matrix update on each accepted byte.
    always_comb begin
        matrix_d = matrix_q;
        rel_d    = rel_q;
        ext_d    = ext_q;
        if (byte_valid_q) begin
            if (rx_byte_q == PS2_REL) begin
                rel_d = 1'b1;
            end else if (rx_byte_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte_q == PS2_ERR0 || rx_byte_q == PS2_ERR1) begin
                matrix_d = '0;
                rel_d    = 1'b0;
                ext_d    = 1'b0;
            end else begin
                if (loc.hit && loc.row < ROW_W'(KEY_ROWS)) begin
                    matrix_d[loc.row][loc.col] = ~rel_q;
                end
                rel_d = 1'b0;
                ext_d = 1'b0;
            end
        end
    end

    always_comb begin
        keyin = 8'hFF;
        if (keyrow < ROW_W'(KEY_ROWS)) begin
            keyin = ~matrix_q[keyrow];
        end
    end

endmodule

// File: tb/tb_pet2001_ps2_key.sv
// Scoreboard bench: stimulus sends PS/2 frames and queues row/keyin expectations; monitor scans rows and checks.
module tb_pet2001_ps2_key;

    localparam int unsigned TIMEOUT = 20000;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] keyrow;
    logic [7:0] keyin;

    typedef struct {
        string      name;
        logic [3:0] row;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    pet2001_ps2_key #(.TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .keyrow   (keyrow),
        .keyin    (keyin)
    );

    always #5 clk = ~clk;

    // Monitor: owns keyrow, pops one expectation per cycle and compares.
    initial begin
        exp_t e;
        keyrow = 4'd0;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                keyrow = e.row;
                #1;
                vectors++;
                if (keyin !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s: keyrow=%0d keyin=%h expected %h", e.name, e.row, keyin, e.exp);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    task automatic expect_row(input string name, input logic [3:0] row, input logic [7:0] exp);
        exp_t e;
        e.name = name;
        e.row  = row;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations pending, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic ps2_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic flip_par, input logic stop);
        logic [10:0] f;
        f = {stop, (~^b) ^ flip_par, b, 1'b0};
        ps2_bits(f, 11);
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_ok(input logic [7:0] b);
        send(b, 1'b0, 1'b1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);

        expect_row("reset_row0", 4'd0, 8'hFF);
        expect_row("reset_row4", 4'd4, 8'hFF);
        expect_row("reset_row9", 4'd9, 8'hFF);
        expect_row("reset_row15", 4'd15, 8'hFF);
        drain();
        reset = 1'b0;
        repeat (4) @(negedge clk);

        send_ok(8'h1C);
        expect_row("a_make_row4", 4'd4, 8'hFE);
        expect_row("a_make_row3", 4'd3, 8'hFF);
        drain();
        send_ok(8'hF0); send_ok(8'h1C);
        expect_row("a_break_row4", 4'd4, 8'hFF);
        drain();

        send_ok(8'h12); send_ok(8'h1C);
        expect_row("shift_a_row8", 4'd8, 8'hFE);
        expect_row("shift_a_row4", 4'd4, 8'hFE);
        drain();
        send_ok(8'hF0); send_ok(8'h1C);
        expect_row("a_rel_row4", 4'd4, 8'hFF);
        expect_row("shift_held_row8", 4'd8, 8'hFE);
        drain();
        send_ok(8'hF0); send_ok(8'h12);
        expect_row("shift_rel_row8", 4'd8, 8'hFF);
        drain();

        send(8'h1C, 1'b1, 1'b1);
        expect_row("bad_parity_row4", 4'd4, 8'hFF);
        drain();
        send(8'h1C, 1'b0, 1'b0);
        expect_row("bad_stop_row4", 4'd4, 8'hFF);
        expect_row("bad_stop_row0", 4'd0, 8'hFF);
        expect_row("bad_stop_row8", 4'd8, 8'hFF);
        drain();
        send_ok(8'h1C);
        expect_row("after_bad_row4", 4'd4, 8'hFE);
        drain();
        send_ok(8'hF0); send_ok(8'h1C);

        send_ok(8'hE0); send_ok(8'h75);
        expect_row("up_make_row1", 4'd1, 8'hFE);
        drain();
        send_ok(8'hE0); send_ok(8'hF0); send_ok(8'h75);
        expect_row("up_break_row1", 4'd1, 8'hFF);
        drain();
        send_ok(8'h75);
        expect_row("plain75_row1", 4'd1, 8'hFF);
        drain();

        send_ok(8'hF0); send_ok(8'h05); send_ok(8'h1C);
        expect_row("miss_clears_rel", 4'd4, 8'hFE);
        drain();
        send_ok(8'h23);
        expect_row("two_keys_row4", 4'd4, 8'hFC);
        drain();
        send_ok(8'h1C);
        expect_row("repeat_make_row4", 4'd4, 8'hFC);
        drain();
        send_ok(8'hFF);
        expect_row("overflow_row4", 4'd4, 8'hFF);
        expect_row("overflow_row12", 4'd12, 8'hFF);
        drain();

        ps2_bits(11'b000_0001_1010, 5);
        repeat (TIMEOUT + 1) @(negedge clk);
        send_ok(8'h5A);
        expect_row("timeout_then_ret", 4'd6, 8'hDF);
        drain();

        send_ok(8'h1C);
        expect_row("held_before_reset", 4'd4, 8'hFE);
        drain();
        ps2_bits(11'b000_0000_0110, 4);
        pulse_reset();
        expect_row("reset_clr_row4", 4'd4, 8'hFF);
        expect_row("reset_clr_row6", 4'd6, 8'hFF);
        expect_row("reset_row12", 4'd12, 8'hFF);
        drain();
        send_ok(8'h1C);
        expect_row("post_reset_row4", 4'd4, 8'hFE);
        expect_row("post_reset_row6", 4'd6, 8'hFF);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
